// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift/compare ops plus an optional
// iterative shift-add multiplier enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       gin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] sum,
   output logic             busy,
   output logic             done,
   output logic             zout,
   output logic             nout,
   output logic             vout,
   output logic             cout,
   output logic             err
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1001;
   localparam logic [3:0] OP_SLTU = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;

   logic [WIDTH-1:0] r_sum;
   logic             r_done;
   logic             r_z;
   logic             r_n;
   logic             r_v;
   logic             r_c;
   logic             r_err;

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic             w_add_v;
   logic             w_sub_v;
   logic [WIDTH-1:0] w_res;
   logic             w_v;
   logic             w_c;
   logic             w_err;
   logic             w_accept;
   logic             w_mul_go;

   assign w_add   = {1'b0, a} + {1'b0, b};
   assign w_sub   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign w_add_v = (a[WIDTH-1] == b[WIDTH-1]) & (w_add[WIDTH-1] != a[WIDTH-1]);
   assign w_sub_v = (a[WIDTH-1] != b[WIDTH-1]) & (w_sub[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      w_res = '0;
      w_v   = 1'b0;
      w_c   = 1'b0;
      w_err = 1'b0;
      case (gin)
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_ADD:  begin
            w_res = w_add[WIDTH-1:0];
            w_v   = w_add_v;
            w_c   = w_add[WIDTH];
         end
         OP_SLL:  w_res = b << shamt;
         OP_SRL:  w_res = b >> shamt;
         OP_SRA:  w_res = $signed(b) >>> shamt;
         OP_SUB:  begin
            w_res = w_sub[WIDTH-1:0];
            w_v   = w_sub_v;
            w_c   = w_sub[WIDTH];
         end
         // Signed less-than must account for overflow, not just the difference sign.
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_v};
         OP_XOR:  w_res = a ^ b;
         OP_NOR:  w_res = ~(a | b);
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, ~w_sub[WIDTH]};
`ifdef ALU_SEQ_MUL_EN
         OP_MUL:  w_res = '0;
`endif
         default: w_err = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic {ST_IDLE, ST_MUL} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] w_acc_next;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});
   assign busy       = (r_state == ST_MUL);
   assign w_mul_go   = w_accept & (gin == OP_MUL);
`else
   assign busy       = 1'b0;
   assign w_mul_go   = 1'b0;
`endif

   assign w_accept = start & ~busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sum    <= '0;
         r_done   <= 1'b0;
         r_z      <= 1'b1;
         r_n      <= 1'b0;
         r_v      <= 1'b0;
         r_c      <= 1'b0;
         r_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         r_state  <= ST_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_accept && !w_mul_go) begin
            r_sum  <= w_res;
            r_z    <= ~|w_res;
            r_n    <= w_res[WIDTH-1];
            r_v    <= w_v;
            r_c    <= w_c;
            r_err  <= w_err;
            r_done <= 1'b1;
         end
`ifdef ALU_SEQ_MUL_EN
         case (r_state)
            ST_IDLE: begin
               if (w_mul_go) begin
                  r_state  <= ST_MUL;
                  r_mcand  <= a;
                  r_mplier <= b;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            ST_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               // Last multiplier bit consumed: publish the product this edge.
               if (r_cnt == SHW'(WIDTH-1)) begin
                  r_state <= ST_IDLE;
                  r_sum   <= w_acc_next;
                  r_z     <= ~|w_acc_next;
                  r_n     <= w_acc_next[WIDTH-1];
                  r_v     <= 1'b0;
                  r_c     <= 1'b0;
                  r_err   <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
`endif
      end
   end

   assign sum  = r_sum;
   assign done = r_done;
   assign zout = r_z;
   assign nout = r_n;
   assign vout = r_v;
   assign cout = r_c;
   assign err  = r_err;

endmodule
